// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// - state_t      : sequencer state encoding
// - OP_MULT/DIV  : operation codes carried on the op port
// - *_DEF        : default watchdog limit and counter width
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_EXC   = 3'd5
    } state_t;

    localparam logic [1:0] OP_MULT     = 2'b01;
    localparam logic [1:0] OP_DIV      = 2'b10;
    localparam int         TIMEOUT_DEF = 40;
    localparam int         CNT_W_DEF   = 6;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Bundle between the control unit / arithmetic units and the sequencer.
// master: control side (drives start/op/flush and the unit status flags)
// slave : the sequencer (drives unit enables/resets, HI/LO writes, status)
interface muldiv_seq_if;

    logic       start;
    logic [1:0] op;
    logic       flush;
    logic       mult_end;
    logic       div_done;
    logic       div_by0;

    logic       mult_control;
    logic       DivOp;
    logic       mult_reset;
    logic       div_reset;
    logic       HI_w;
    logic       LO_w;
    logic       hilo_sel;
    logic       busy;
    logic       done;
    logic       exc_divby0;
    logic       exc_timeout;

    modport master (
        output start, op, flush, mult_end, div_done, div_by0,
        input  mult_control, DivOp, mult_reset, div_reset, HI_w, LO_w,
               hilo_sel, busy, done, exc_divby0, exc_timeout
    );

    modport slave (
        input  start, op, flush, mult_end, div_done, div_by0,
        output mult_control, DivOp, mult_reset, div_reset, HI_w, LO_w,
               hilo_sel, busy, done, exc_divby0, exc_timeout
    );

endinterface

// File: rtl/muldiv_watchdog.sv
// Watchdog for the RUN phase of the sequencer.
// Ports: clk, reset (sync, active-high), clear (zero the count),
//        enable (count up), expire (count has reached TIMEOUT-1).
module muldiv_watchdog
    import muldiv_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expire = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for a shared multiplier/divider: clears the selected unit,
// runs it under a watchdog, then writes HI/LO or raises an exception.
// Ports: clk, reset (sync, active-high), bus (muldiv_seq_if.slave).
//
// state | meaning
// IDLE  | waiting for start with a valid op
// CLR   | one-cycle clear pulse to the selected unit
// RUN   | unit enabled, watchdog counting
// WRITE | HI/LO write enables for one cycle
// DONE  | completion pulse
// EXC   | divide-by-zero or timeout pulse, active unit cleared
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_seq_if.slave    bus
);

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       mult_control_q, mult_control_d;
    logic       div_op_q, div_op_d;
    logic       mult_reset_q, mult_reset_d;
    logic       div_reset_q, div_reset_d;
    logic       hilo_w_q, hilo_w_d;
    logic       done_q, done_d;
    logic       exc_divby0_q, exc_divby0_d;
    logic       exc_timeout_q, exc_timeout_d;
    logic       busy_q, busy_d;
    logic       wd_expire;
    logic       is_div;
    logic       unit_done;
    logic       flushing;

    muldiv_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == ST_CLR),
        .enable (state_q == ST_RUN),
        .expire (wd_expire)
    );

    assign is_div    = (op_q == OP_DIV);
    // Only the active unit's completion flag counts.
    assign unit_done = is_div ? bus.div_done : bus.mult_end;
    assign flushing  = bus.flush && (state_q != ST_IDLE);

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        mult_control_d = 1'b0;
        div_op_d       = 1'b0;
        mult_reset_d   = 1'b0;
        div_reset_d    = 1'b0;
        hilo_w_d       = 1'b0;
        done_d         = 1'b0;
        exc_divby0_d   = 1'b0;
        exc_timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && op_valid(bus.op)) begin
                    op_d    = bus.op;
                    state_d = ST_CLR;
                end
            end
            ST_CLR:   state_d = ST_RUN;
            ST_RUN: begin
                // div-by-zero beats completion; completion beats timeout
                if (is_div && bus.div_by0) begin
                    state_d      = ST_EXC;
                    exc_divby0_d = 1'b1;
                end else if (unit_done) begin
                    state_d = ST_WRITE;
                end else if (wd_expire) begin
                    state_d       = ST_EXC;
                    exc_timeout_d = 1'b1;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_EXC:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (flushing) begin
            state_d       = ST_IDLE;
            exc_divby0_d  = 1'b0;
            exc_timeout_d = 1'b0;
        end

        // Outputs are registered as a function of the state being entered.
        case (state_d)
            ST_CLR, ST_EXC: begin
                mult_reset_d = (op_d == OP_MULT);
                div_reset_d  = (op_d == OP_DIV);
            end
            ST_RUN: begin
                mult_control_d = (op_d == OP_MULT);
                div_op_d       = (op_d == OP_DIV);
            end
            ST_WRITE: hilo_w_d = 1'b1;
            ST_DONE:  done_d   = 1'b1;
            default: ;
        endcase

        // An aborted op leaves both units cleared.
        if (flushing) begin
            mult_reset_d = 1'b1;
            div_reset_d  = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            mult_control_q <= 1'b0;
            div_op_q       <= 1'b0;
            mult_reset_q   <= 1'b0;
            div_reset_q    <= 1'b0;
            hilo_w_q       <= 1'b0;
            done_q         <= 1'b0;
            exc_divby0_q   <= 1'b0;
            exc_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            mult_control_q <= mult_control_d;
            div_op_q       <= div_op_d;
            mult_reset_q   <= mult_reset_d;
            div_reset_q    <= div_reset_d;
            hilo_w_q       <= hilo_w_d;
            done_q         <= done_d;
            exc_divby0_q   <= exc_divby0_d;
            exc_timeout_q  <= exc_timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.mult_control = mult_control_q;
    assign bus.DivOp        = div_op_q;
    assign bus.mult_reset   = mult_reset_q;
    assign bus.div_reset    = div_reset_q;
    assign bus.HI_w         = hilo_w_q;
    assign bus.LO_w         = hilo_w_q;
    // Latched op stays put until the next accepted start.
    assign bus.hilo_sel     = (op_q == OP_DIV);
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.exc_divby0   = exc_divby0_q;
    assign bus.exc_timeout  = exc_timeout_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: two instances (TIMEOUT 40 and 8) share one directed
// stimulus timeline; a transaction-level model writes the expected output
// timeline of each instance, checked every cycle.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int N    = 170;
    localparam int TO_A = 40;
    localparam int TO_B = 8;

    typedef struct packed {
        logic mc, dv, mr, dr, hw, lw, hs, busy, done, ed, et;
    } outs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_seq_if bus_a ();
    muldiv_seq_if bus_b ();

    muldiv_seq dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    muldiv_seq #(.TIMEOUT(TO_B), .CNT_W(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    outs_t act [2];
    assign act[0] = {bus_a.mult_control, bus_a.DivOp, bus_a.mult_reset, bus_a.div_reset,
                     bus_a.HI_w, bus_a.LO_w, bus_a.hilo_sel, bus_a.busy, bus_a.done,
                     bus_a.exc_divby0, bus_a.exc_timeout};
    assign act[1] = {bus_b.mult_control, bus_b.DivOp, bus_b.mult_reset, bus_b.div_reset,
                     bus_b.HI_w, bus_b.LO_w, bus_b.hilo_sel, bus_b.busy, bus_b.done,
                     bus_b.exc_divby0, bus_b.exc_timeout};

    logic       s_start [N];
    logic [1:0] s_op    [N];
    logic       s_flush [N];
    logic       s_reset [N];
    logic       s_mend  [N];
    logic       s_ddone [N];
    logic       s_dby0  [N];
    outs_t      exp_o   [2][N];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit run_chk  = 1'b0;

    // kind: 0 = completion flag at n, 1 = div-by-zero at n, 2 = no flag,
    //       3 = invalid op. a >= 0 aborts at cycle a (reset if a_rst, else flush).
    task automatic txn(input int t0, input logic [1:0] o, input int kind,
                       input int n, input int a, input bit a_rst);
        s_start[t0] = 1'b1;
        s_op[t0]    = o;
        if (kind == 3) return;
        if (kind == 0) begin
            if (o == OP_MULT) s_mend[n] = 1'b1;
            else              s_ddone[n] = 1'b1;
        end
        if (kind == 1) begin
            s_dby0[n]  = 1'b1;
            s_ddone[n] = 1'b1;
        end
        if (a >= 0) begin
            if (a_rst) s_reset[a] = 1'b1;
            else       s_flush[a] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            int tmo, re, last;
            bit by_flag;
            tmo     = (k == 0) ? TO_A : TO_B;
            by_flag = (kind != 2) && (n <= t0 + 1 + tmo);
            re      = by_flag ? n : t0 + 1 + tmo;
            last    = (by_flag && kind == 0) ? n + 2 : re + 1;
            for (int c = t0 + 1; c <= last && c < N; c++) begin
                if (a >= 0 && c > a) break;
                exp_o[k][c].busy = 1'b1;
                if (c == t0 + 1) begin
                    exp_o[k][c].mr = (o == OP_MULT);
                    exp_o[k][c].dr = (o == OP_DIV);
                end else if (c <= re) begin
                    exp_o[k][c].mc = (o == OP_MULT);
                    exp_o[k][c].dv = (o == OP_DIV);
                end else if (by_flag && kind == 0) begin
                    if (c == re + 1) begin
                        exp_o[k][c].hw = 1'b1;
                        exp_o[k][c].lw = 1'b1;
                    end else begin
                        exp_o[k][c].done = 1'b1;
                    end
                end else begin
                    exp_o[k][c].ed = by_flag;
                    exp_o[k][c].et = !by_flag;
                    exp_o[k][c].mr = (o == OP_MULT);
                    exp_o[k][c].dr = (o == OP_DIV);
                end
            end
            for (int c = t0 + 1; c < N; c++) exp_o[k][c].hs = (o == OP_DIV);
            if (a >= 0 && a <= last) begin
                if (a_rst) begin
                    for (int c = a + 1; c < N; c++) exp_o[k][c].hs = 1'b0;
                end else if (a + 1 < N) begin
                    exp_o[k][a+1].mr = 1'b1;
                    exp_o[k][a+1].dr = 1'b1;
                end
            end
        end
    endtask

    task automatic pin(input string name, input outs_t got, input outs_t want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL pin_%s model=%b want=%b", name, got, want);
        end
    endtask

    task automatic drive(input int c);
        reset       = s_reset[c];
        bus_a.start = s_start[c];  bus_b.start = s_start[c];
        bus_a.op    = s_op[c];     bus_b.op    = s_op[c];
        bus_a.flush = s_flush[c];  bus_b.flush = s_flush[c];
        bus_a.mult_end = s_mend[c];  bus_b.mult_end = s_mend[c];
        bus_a.div_done = s_ddone[c]; bus_b.div_done = s_ddone[c];
        bus_a.div_by0  = s_dby0[c];  bus_b.div_by0  = s_dby0[c];
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (act[k] !== exp_o[k][cyc]) begin
                    n_fail++;
                    $display("FAIL dut_%s cyc=%0d got=%b exp=%b (mc dv mr dr hw lw hs busy done ed et)",
                             (k == 0) ? "a" : "b", cyc, act[k], exp_o[k][cyc]);
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < N; c++) begin
            s_start[c] = 1'b0; s_op[c] = 2'b00; s_flush[c] = 1'b0; s_reset[c] = 1'b0;
            s_mend[c] = 1'b0; s_ddone[c] = 1'b0; s_dby0[c] = 1'b0;
            exp_o[0][c] = '0; exp_o[1][c] = '0;
        end

        // MULT, long run (B times out); inactive flags and start ignored while busy
        txn(0, OP_MULT, 0, 34, -1, 1'b0);
        s_start[5] = 1'b1; s_op[5] = OP_DIV;
        s_ddone[6] = 1'b1;
        s_dby0[7]  = 1'b1;
        // back-to-back DIV by zero with div_done in the same cycle
        txn(37, OP_DIV, 1, 42, -1, 1'b0);
        // DIV flushed in RUN, start during run ignored, flush in IDLE harmless
        txn(44, OP_DIV, 2, 0, 48, 1'b0);
        s_start[46] = 1'b1; s_op[46] = OP_MULT;
        s_flush[52] = 1'b1;
        // invalid ops
        txn(55, 2'b11, 3, 0, -1, 1'b0);
        txn(56, 2'b00, 3, 0, -1, 1'b0);
        // reset mid MULT, together with flush
        txn(60, OP_MULT, 2, 0, 63, 1'b1);
        s_flush[63] = 1'b1;
        // DIV completes exactly on B's last watchdog cycle; mult_end ignored
        txn(70, OP_DIV, 0, 79, -1, 1'b0);
        s_mend[74] = 1'b1;
        // DIV timeout on both instances
        txn(90, OP_DIV, 2, 0, -1, 1'b0);
        // flush during WRITE, flush during CLR
        txn(140, OP_MULT, 0, 145, 146, 1'b0);
        txn(150, OP_DIV, 2, 0, 151, 1'b0);
        // short MULT
        txn(160, OP_MULT, 0, 163, -1, 1'b0);

        pin("a2_run",     exp_o[0][2],   11'b10000001000);
        pin("a35_write",  exp_o[0][35],  11'b00001101000);
        pin("a36_done",   exp_o[0][36],  11'b00000001100);
        pin("a37_idle",   exp_o[0][37],  11'b00000000000);
        pin("b10_tmo",    exp_o[1][10],  11'b00100001001);
        pin("a43_divby0", exp_o[0][43],  11'b00010011010);
        pin("a49_flush",  exp_o[0][49],  11'b00110010000);
        pin("a64_reset",  exp_o[0][64],  11'b00000000000);
        pin("b80_write",  exp_o[1][80],  11'b00001111000);
        pin("a147_flush", exp_o[0][147], 11'b00110000000);

        reset = 1'b1;
        bus_a.start = 1'b0; bus_b.start = 1'b0;
        bus_a.op = 2'b00;   bus_b.op = 2'b00;
        bus_a.flush = 1'b0; bus_b.flush = 1'b0;
        bus_a.mult_end = 1'b0; bus_b.mult_end = 1'b0;
        bus_a.div_done = 1'b0; bus_b.div_done = 1'b0;
        bus_a.div_by0 = 1'b0;  bus_b.div_by0 = 1'b0;
        repeat (3) @(posedge clk);

        for (int c = 0; c < N; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            drive(c);
            run_chk = 1'b1;
        end
        @(posedge clk);
        #1;
        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
